// File: rtl/mem_initiator_pkg.sv
// Shared types and default sizing for the mem_initiator bus-master front end.
package mem_initiator_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 16384;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RDATA,
    WRITE,
    RESP
  } state_e;

endpackage

// File: rtl/mem_initiator_reg.sv
// Load-enable register with asynchronous active-high clear; used for MAR and MBR.
module mem_initiator_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_initiator.sv
// Single-outstanding read/write sequencer in front of a registered-read memory.
// Define MEM_INITIATOR_RANGE_CHECK_EN to reject addresses >= MEM_DEPTH with rsp_err.
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int ADDR_W    = mem_initiator_pkg::ADDR_W,
  parameter int DATA_W    = mem_initiator_pkg::DATA_W,
  parameter int MEM_DEPTH = mem_initiator_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_data_out
);

`ifdef MEM_INITIATOR_RANGE_CHECK_EN
  localparam bit RANGE_CHECK_EN = 1'b1;
`else
  localparam bit RANGE_CHECK_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mbr_q, mbr_d;
  logic              mar_load, mbr_load;
  logic              err_q, err_d;
  logic              addr_oor;

  // One extra bit keeps the compare correct even when MEM_DEPTH == 2**ADDR_W.
  assign addr_oor = RANGE_CHECK_EN &&
                    ({1'b0, req_addr} >= (ADDR_W+1)'(MEM_DEPTH));

  mem_initiator_reg #(.W(ADDR_W)) u_mar (
    .clk    (clk),
    .rst    (reset),
    .load_i (mar_load),
    .d_i    (req_addr),
    .q_o    (mar_q)
  );

  mem_initiator_reg #(.W(DATA_W)) u_mbr (
    .clk    (clk),
    .rst    (reset),
    .load_i (mbr_load),
    .d_i    (mbr_d),
    .q_o    (mbr_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mar_load = 1'b0;
    mbr_load = 1'b0;
    mbr_d    = req_wdata;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mar_load = 1'b1;
          mbr_load = 1'b1;
          err_d    = addr_oor;
          if (addr_oor) begin
            mbr_d   = '0;
            state_d = RESP;
          end else begin
            state_d = req_write ? WRITE : READ;
          end
        end
      end
      READ:  state_d = RDATA;
      RDATA: begin
        mbr_load = 1'b1;
        mbr_d    = mem_data_out;
        state_d  = RESP;
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready        = (state_q == IDLE);
  assign rsp_valid        = (state_q == RESP);
  assign rsp_data         = mbr_q;
  assign rsp_err          = err_q;
  assign mem_addr         = mar_q;
  assign mem_data_in      = mbr_q;
  assign mem_write_enable = (state_q == WRITE);

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized bench for mem_initiator with a transaction-latency reference model.
module tb_mem_initiator;

  localparam int DEPTH = 16384;
`ifdef MEM_INITIATOR_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_write_enable;
  logic [15:0] rsp_data, mem_addr, mem_data_in, mem_data_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int we_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_initiator dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_write_enable),
    .mem_data_out     (mem_data_out)
  );

  // Physical memory: synchronous write, registered read.
  logic [15:0] mem [DEPTH];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enable && mem_addr < DEPTH) mem[mem_addr[13:0]] <= mem_data_in;
    mem_data_out <= (mem_addr < DEPTH) ? mem[mem_addr[13:0]] : 16'h0;
  end

  always @(negedge clk) if (mem_write_enable) we_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the memory should hold and what each accepted
  // request must produce, counted in edges since acceptance.
  logic [15:0] gold [DEPTH];
  bit          m_busy = 0, m_write = 0, m_oor = 0, m_err = 0;
  int          m_cnt = 0, m_lat = 0;
  logic [15:0] m_addr = '0, m_mbr = '0;

  function automatic logic [15:0] gold_rd(input logic [15:0] a);
    return (a < DEPTH) ? gold[a[13:0]] : 16'h0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_cnt = 0; m_addr = '0; m_mbr = '0; m_err = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  = 1;
        m_cnt   = 1;
        m_write = req_write;
        m_addr  = req_addr;
        m_oor   = RC && (req_addr >= DEPTH);
        m_err   = m_oor;
        m_mbr   = m_oor ? 16'h0 : req_wdata;
        m_lat   = m_oor ? 1 : (req_write ? 2 : 3);
      end
    end else if (m_cnt < m_lat) begin
      m_cnt++;
      if (m_write && m_cnt == 2 && m_addr < DEPTH) gold[m_addr[13:0]] = m_mbr;
      if (!m_write && m_cnt == 3) m_mbr = gold_rd(m_addr);
    end else if (rsp_ready) begin
      m_busy = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      check("req_ready", req_ready, !m_busy);
      check("rsp_valid", rsp_valid, m_busy && m_cnt == m_lat);
      check("mem_we", mem_write_enable, m_busy && m_write && !m_oor && m_cnt == 1);
      check("mem_addr", mem_addr, m_addr);
      check("mem_data_in", mem_data_in, m_mbr);
      if (m_busy && m_cnt == m_lat) begin
        check("rsp_data", rsp_data, m_mbr);
        check("rsp_err", rsp_err, m_err);
      end
    end
  end

  // Issue one request at a negedge; scramble req_* right after acceptance.
  task automatic txn(input bit w, input logic [15:0] a, input logic [15:0] d, input int hold,
                     output logic [15:0] rd, output logic re, output int edges);
    int g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    if (g >= 20) check("req_ready_timeout", req_ready, 1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 0; req_wdata = 16'hFFFF; req_addr = 16'($urandom); req_write = 1'($urandom);
    edges = 1;
    while (!rsp_valid && edges < 20) begin @(negedge clk); edges++; end
    rd = rsp_data; re = rsp_err;
    repeat (hold) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_data_in"}, mem_data_in, 0);
    check({tag, "_mem_we"}, mem_write_enable, 0);
  endtask

  initial begin
    logic [15:0] rd, v;
    logic        re;
    int          edges, w0, prev, g, mism;

    for (int i = 0; i < DEPTH; i++) begin
      v = 16'($urandom);
      mem[i] <= v;
      gold[i] = v;
    end
    mem[3] <= 16'h1234;     gold[3] = 16'h1234;
    mem[16'h20] <= 16'h0BAD; gold[16'h20] = 16'h0BAD;

    repeat (3) @(negedge clk);
    reset = 0;
    check_reset_outputs("reset");
    chk_en = 1;

    // Write then read back.
    w0 = we_cnt;
    txn(1, 16'h0010, 16'hBEEF, 0, rd, re, edges);
    check("wr_latency", edges, 2);
    check("wr_rsp_data", rd, 16'hBEEF);
    check("wr_we_cycles", we_cnt - w0, 1);
    txn(0, 16'h0010, 16'h0000, 0, rd, re, edges);
    check("rd_latency", edges, 3);
    check("rd_data", rd, 16'hBEEF);
    check("rd_err", re, 0);

    // Backpressure on the response.
    txn(0, 16'h0003, 16'h0000, 5, rd, re, edges);
    check("bp_data", rd, 16'h1234);
    check("bp_latency", edges, 3);

    // Write data changed after acceptance must not reach memory.
    txn(1, 16'h0005, 16'h00AA, 1, rd, re, edges);
    check("wstab_rsp", rd, 16'h00AA);
    check("wstab_mem", mem[5], 16'h00AA);

    // Back-to-back reads with rsp_ready held high.
    rsp_ready = 1; req_valid = 1; req_write = 0; prev = 0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 16'(i);
      g = 0;
      while (!req_ready && g < 20) begin @(negedge clk); g++; end
      if (i > 0) check("b2b_spacing", cyc - prev, 4);
      prev = cyc;
      @(negedge clk);
    end
    req_valid = 0;
    repeat (4) @(negedge clk);
    rsp_ready = 0;

    // Out-of-range requests.
    w0 = we_cnt;
    txn(0, 16'h4000, 16'h0000, 0, rd, re, edges);
`ifdef MEM_INITIATOR_RANGE_CHECK_EN
    check("oor_rd_latency", edges, 1);
    check("oor_rd_err", re, 1);
    check("oor_rd_data", rd, 0);
    txn(1, 16'hFFFF, 16'h7777, 0, rd, re, edges);
    check("oor_wr_latency", edges, 1);
    check("oor_wr_err", re, 1);
    check("oor_we_cycles", we_cnt - w0, 0);
`else
    check("oor_rd_latency", edges, 3);
    check("oor_rd_err", re, 0);
`endif

    // Reset while a write is in its WRITE cycle.
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    req_valid = 1; req_write = 1; req_addr = 16'h0020; req_wdata = 16'h5555;
    @(posedge clk);
    #1 req_valid = 0;
    check("rst_we_before", mem_write_enable, 1);
    #2 reset = 1;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    check_reset_outputs("postrst");
    check("midrst_mem", mem[16'h20], 16'h0BAD);

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      logic [15:0] a;
      a = ($urandom % 8 == 0) ? 16'($urandom) : 16'($urandom % 32);
      txn(1'($urandom), a, 16'($urandom), int'($urandom % 3), rd, re, edges);
      repeat ($urandom % 2) @(negedge clk);
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== gold[i]) mism++;
    check("mem_image", mism, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
